ctrl_seq: RTL
=============

// Module: ctrl_seq
// PURPOSE
//  Microcode sequencer for the 8-bit bus CPU: steps T-states and drives every bus
//  load/drive strobe (PC, MAR, RAM, IR, A, B, ALU, OUT) from the IR opcode and flags.
//  Sits beside the RAM/register file; sole owner of ram_in/ram_out and bus-drive enables.
// PARAMETERS
//  OPW      4   opcode width (IR[7:4])
//  TSTEPS   5   T-states per instruction max (T0..T4), step counter width 3
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst_n     in   1  asynchronous active-low reset
//  run       in   1  1=advance one T-state per clk; 0=freeze state, all strobes forced 0
//  ir_op     in   4  opcode from IR upper nibble, valid from T2
//  flag_c    in   1  latched carry flag
//  flag_z    in   1  latched zero flag
//  pc_out    out  1  PC drives bus
//  pc_inc    out  1  PC increments at clk edge
//  pc_load   out  1  PC loads bus[3:0]
//  mar_in    out  1  MAR loads bus[3:0]
//  ram_in    out  1  RAM[MAR] <= bus
//  ram_out   out  1  RAM[MAR] drives bus
//  ir_in     out  1  IR loads bus
//  ir_out    out  1  IR[3:0] drives bus (upper bits 0)
//  a_in/a_out out 1  A register load / drive
//  b_in      out  1  B register load
//  alu_out   out  1  ALU result drives bus
//  alu_sub   out  1  ALU subtract select
//  flags_in  out  1  flags register captures C/Z
//  out_in    out  1  output register loads bus
//  halted    out  1  1 while in HALT
//  step      out  3  current T-state index (debug)
// BEHAVIOUR
//  States: RST, T0..T4, HALT. rst_n low (any time, async) -> RST; all outputs 0, step=0.
//  RST -> T0 on first clk with run=1. Strobes are Moore: decoded from state+ir_op+flags.
//  Fetch: T0 pc_out,mar_in. T1 ram_out,ir_in,pc_inc. Always T0->T1->T2.
//  Execute (op: steps; final step returns to T0 next clk, unused steps skipped):
//   0 NOP      T2 none
//   1 LDA      T2 ir_out,mar_in; T3 ram_out,a_in
//   2 ADD      T2 ir_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in
//   3 SUB      as ADD, alu_sub=1 in T4
//   4 STA      T2 ir_out,mar_in; T3 a_out,ram_in
//   5 LDI      T2 ir_out,a_in
//   6 JMP      T2 ir_out,pc_load
//   7 JC       T2 ir_out,pc_load only if flag_c=1, else none
//   8 JZ       T2 ir_out,pc_load only if flag_z=1, else none
//   14 OUT     T2 a_out,out_in
//   15 HLT     T2 none; next state HALT
//   9-13       undefined: treated as NOP
//  Cycle counts: NOP/LDI/JMP/Jx/OUT 3, LDA/STA 4, ADD/SUB 5.
//  HALT: all strobes 0, halted=1, step=0; exits only via reset.
//  run=0: state/step held, all strobes 0; resumes same T-state when run=1.
//  Invariant: at most one of pc_out,ram_out,ir_out,a_out,alu_out high per cycle;
//   ram_in and ram_out never both high.
//  Reset mid-instruction aborts it; no strobe asserted during or after until T0.
// TESTING
//  1 Reset: rst_n=0 mid-T3 -> all outputs 0 immediately; release,run=1 -> T0 strobes next clk.
//  2 LDA 15 then ADD 15 (ir_op=1,2) -> strobe trace matches table; 4 then 5 cycles to T0.
//  3 JC with flag_c=0 -> no pc_load, T0 after 3 cycles; flag_c=1 -> ir_out,pc_load in T2.
//  4 STA (op 4) -> T3 has a_out,ram_in only; ram_out=0 throughout T3.
//  5 HLT (op 15) -> halted=1 from T2+1, stays for 20 clks regardless of run/ir_op.
//  6 Random ops/flags/run 10k cycles -> bus single-driver invariant never violated.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// Bus-control bundle between the microcode sequencer (master) and the datapath (slave).
// The master consumes run/opcode/flags and produces every load/drive strobe.
interface ctrl_seq_if #(
   parameter int OPW = 4
);
   logic           run;
   logic [OPW-1:0] ir_op;
   logic           flag_c;
   logic           flag_z;

   logic           pc_out;
   logic           pc_inc;
   logic           pc_load;
   logic           mar_in;
   logic           ram_in;
   logic           ram_out;
   logic           ir_in;
   logic           ir_out;
   logic           a_in;
   logic           a_out;
   logic           b_in;
   logic           alu_out;
   logic           alu_sub;
   logic           flags_in;
   logic           out_in;
   logic           halted;
   logic [2:0]     step;

   modport master (
      input  run, ir_op, flag_c, flag_z,
      output pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
             a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, step
   );

   modport slave (
      output run, ir_op, flag_c, flag_z,
      input  pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
             a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, step
   );
endinterface

// File: rtl/ctrl_seq.sv
// Microcode sequencer for the 8-bit bus CPU: walks T-states and decodes the bus
// strobes (Moore) from the current state, the IR opcode and the latched flags.
module ctrl_seq #(
   parameter int OPW    = 4,
   parameter int TSTEPS = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   ctrl_seq_if.master    bus
);

   localparam int STEPW = $clog2(TSTEPS);

   localparam logic [OPW-1:0] OP_LDA = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB = OPW'(3);
   localparam logic [OPW-1:0] OP_STA = OPW'(4);
   localparam logic [OPW-1:0] OP_LDI = OPW'(5);
   localparam logic [OPW-1:0] OP_JMP = OPW'(6);
   localparam logic [OPW-1:0] OP_JC  = OPW'(7);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
   localparam logic [OPW-1:0] OP_OUT = OPW'(14);
   localparam logic [OPW-1:0] OP_HLT = OPW'(15);

   typedef enum logic [2:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_HALT
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [STEPW-1:0] step_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // HALT is only left through reset; otherwise run=0 freezes the current T-state.
   always_comb begin
      state_d = state_q;
      if (state_q != ST_HALT && bus.run) begin
         case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2: begin
               case (bus.ir_op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = ST_T3;
                  OP_HLT:                         state_d = ST_HALT;
                  default:                        state_d = ST_T0;
               endcase
            end
            ST_T3: begin
               if (bus.ir_op == OP_ADD || bus.ir_op == OP_SUB) begin
                  state_d = ST_T4;
               end else begin
                  state_d = ST_T0;
               end
            end
            ST_T4:   state_d = ST_T0;
            default: state_d = ST_RST;
         endcase
      end
   end

   always_comb begin
      case (state_q)
         ST_T1:   step_d = STEPW'(1);
         ST_T2:   step_d = STEPW'(2);
         ST_T3:   step_d = STEPW'(3);
         ST_T4:   step_d = STEPW'(4);
         default: step_d = STEPW'(0);
      endcase
   end

   assign bus.step   = step_d;
   assign bus.halted = (state_q == ST_HALT);

   // Strobe decode; everything is gated by run so a frozen sequencer drives nothing.
   always_comb begin
      bus.pc_out   = 1'b0;
      bus.pc_inc   = 1'b0;
      bus.pc_load  = 1'b0;
      bus.mar_in   = 1'b0;
      bus.ram_in   = 1'b0;
      bus.ram_out  = 1'b0;
      bus.ir_in    = 1'b0;
      bus.ir_out   = 1'b0;
      bus.a_in     = 1'b0;
      bus.a_out    = 1'b0;
      bus.b_in     = 1'b0;
      bus.alu_out  = 1'b0;
      bus.alu_sub  = 1'b0;
      bus.flags_in = 1'b0;
      bus.out_in   = 1'b0;
      if (bus.run) begin
         case (state_q)
            ST_T0: begin
               bus.pc_out = 1'b1;
               bus.mar_in = 1'b1;
            end
            ST_T1: begin
               bus.ram_out = 1'b1;
               bus.ir_in   = 1'b1;
               bus.pc_inc  = 1'b1;
            end
            ST_T2: begin
               case (bus.ir_op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     bus.ir_out = 1'b1;
                     bus.mar_in = 1'b1;
                  end
                  OP_LDI: begin
                     bus.ir_out = 1'b1;
                     bus.a_in   = 1'b1;
                  end
                  OP_JMP: begin
                     bus.ir_out  = 1'b1;
                     bus.pc_load = 1'b1;
                  end
                  OP_JC: begin
                     bus.ir_out  = bus.flag_c;
                     bus.pc_load = bus.flag_c;
                  end
                  OP_JZ: begin
                     bus.ir_out  = bus.flag_z;
                     bus.pc_load = bus.flag_z;
                  end
                  OP_OUT: begin
                     bus.a_out  = 1'b1;
                     bus.out_in = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            ST_T3: begin
               case (bus.ir_op)
                  OP_LDA: begin
                     bus.ram_out = 1'b1;
                     bus.a_in    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     bus.ram_out = 1'b1;
                     bus.b_in    = 1'b1;
                  end
                  OP_STA: begin
                     bus.a_out  = 1'b1;
                     bus.ram_in = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            ST_T4: begin
               bus.alu_out  = 1'b1;
               bus.a_in     = 1'b1;
               bus.flags_in = 1'b1;
               bus.alu_sub  = (bus.ir_op == OP_SUB);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
